pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves load-use hazards, taken-branch redirects, multi-cycle MDU operations and instruction/data memory wait states. It also keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/load_use_detect.sv | 21 ++
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MDU_LAT_DEF = 4;
    localparam int         CNT_W_DEF   = 32;
    // Wide enough for the largest busy countdown (MDU_LAT-2 = 14).
    localparam int         MDU_CNT_W   = 4;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: the load in EX writes a register the ID instruction reads.
// Purely combinational, zero latency; no flow control.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu
);

    always_comb begin
        lu = ex_mem_read && (ex_rd != REG_ZERO) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline plus saturating stall/flush counters.
// Zero-cycle latency: controls are combinational from inputs and the MDU state; a data memory wait freezes everything.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_op,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam bit                   MDU_MULTI = (MDU_LAT > 1);
    localparam logic [MDU_CNT_W-1:0] CNT_LOAD  = MDU_CNT_W'(MDU_LAT - 2);

    state_t               state, state_nxt;
    logic [MDU_CNT_W-1:0] cnt, cnt_nxt;
    logic                 lu, freeze, br, iw, mdu_start, mdu_stall;

    load_use_detect u_lu (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        freeze    = mem_req && !dmem_ready;
        br        = ex_branch_taken;
        iw        = !imem_ready;
        mdu_start = (state == RUN) && ex_mdu_op && !br && !freeze && MDU_MULTI;
        // The op is held in EX on its first cycle as well, hence the stall on start.
        mdu_stall = (state == MDU_BUSY) ? (cnt != '0) : mdu_start;

        case (state)
            RUN: begin
                if (mdu_start) begin
                    state_nxt = MDU_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MDU_BUSY: begin
                if (cnt != '0) cnt_nxt = cnt - 1'b1;
                if (cnt == '0 && !freeze) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase

        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        if (freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (br && state == RUN) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mdu_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (iw) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end

        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (if_id_flush && flush_events != '1) flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed control vectors, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    localparam int         CW   = 8;
    localparam logic [7:0] MAXC = 8'hFF;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [7:0] NORM = 8'b11111_000;
    localparam logic [7:0] FRZ  = 8'b00000_000;
    localparam logic [7:0] BRF  = 8'b11111_110;
    localparam logic [7:0] MDU  = 8'b00011_001;
    localparam logic [7:0] LUS  = 8'b00111_010;
    localparam logic [7:0] IWS  = 8'b01111_100;
    localparam logic [7:0] RST  = 8'b00000_000;

    typedef struct packed {
        logic [15:0] idx;
        logic [7:0]  ctrl;
        logic [7:0]  st;
        logic [7:0]  fl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_mdu_op;
    logic          imem_ready, mem_req, dmem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush;
    logic [CW-1:0] stall_cycles, flush_events;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  m_stall = '0;
    logic [7:0]  m_flush = '0;
    logic [15:0] vec = '0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MDU_LAT(4), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_mdu_op       (ex_mdu_op),
        .imem_ready      (imem_ready),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mdu_op = 1'b0;
        imem_ready = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic use2);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = use2;
        id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    endtask

    // One cycle: record expectation, advance the counter model, move to next cycle.
    task automatic cyc(input logic [7:0] exp_ctrl);
        if (!rst_n) begin
            m_stall = '0;
            m_flush = '0;
        end
        sb_q.push_back('{idx: vec, ctrl: exp_ctrl, st: m_stall, fl: m_flush});
        vec = vec + 16'd1;
        if (rst_n) begin
            if (!exp_ctrl[7] && m_stall != MAXC) m_stall = m_stall + 8'd1;
            if (exp_ctrl[2] && m_flush != MAXC) m_flush = m_flush + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush};
                checks = checks + 3;
                if (act !== e.ctrl) begin
                    failures = failures + 1;
                    $display("FAIL ctrl vec=%0d actual=%b required=%b", e.idx, act, e.ctrl);
                end
                if (stall_cycles !== e.st) begin
                    failures = failures + 1;
                    $display("FAIL stall_cycles vec=%0d actual=%0d required=%0d", e.idx, stall_cycles, e.st);
                end
                if (flush_events !== e.fl) begin
                    failures = failures + 1;
                    $display("FAIL flush_events vec=%0d actual=%0d required=%0d", e.idx, flush_events, e.fl);
                end
            end
        end
    end

    initial begin : stim
        idle();
        @(posedge clk);
        #1;
        cyc(RST);
        cyc(RST);
        rst_n = 1'b1;
        cyc(NORM);

        // Load-use on rs2: one bubble, then clear.
        set_lu(5'd5, 1'b1); cyc(LUS);
        idle();             cyc(NORM);
        set_lu(5'd0, 1'b1); cyc(NORM);
        set_lu(5'd5, 1'b0); cyc(NORM);

        // Taken branch beats load-use and fetch wait.
        set_lu(5'd5, 1'b1); ex_branch_taken = 1'b1; imem_ready = 1'b0; cyc(BRF);
        idle(); cyc(NORM);

        // Fetch wait alone; freeze beats a taken branch.
        imem_ready = 1'b0; cyc(IWS);
        idle(); mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1; cyc(FRZ);
        idle(); cyc(NORM);

        // MDU, latency 4: three bubbles then the op advances.
        ex_mdu_op = 1'b1;
        cyc(MDU); cyc(MDU); cyc(MDU); cyc(NORM);
        idle(); cyc(NORM);

        // MDU with a 5-cycle data-memory wait during the busy period.
        ex_mdu_op = 1'b1; cyc(MDU);
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc(FRZ);
        mem_req = 1'b0; dmem_ready = 1'b1; cyc(NORM);
        idle(); cyc(NORM);

        // Reset mid-MDU: immediate zero outputs and counters, back in RUN after release.
        ex_mdu_op = 1'b1; cyc(MDU); cyc(MDU);
        rst_n = 1'b0; cyc(RST);
        idle(); rst_n = 1'b1; cyc(NORM);
        cyc(NORM);

        // Long fetch wait drives both counters into saturation.
        imem_ready = 1'b0;
        for (int i = 0; i < 260; i++) cyc(IWS);
        idle(); cyc(NORM);
        cyc(NORM);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
